// File: rtl/gb_pkg.sv
// Shared definitions for the save-RAM upload path: SDRAM placement of cart RAM,
// fill word for out-of-range reads, reader FSM states and the header size decode.
package gb_pkg;

    // SDRAM word address of cart RAM bank 0 (region 0001 in bits 23:20)
    localparam logic [23:0] RAM_BASE  = 24'h100000;
    // Word returned for addresses beyond the save size
    localparam logic [15:0] FILL_WORD = 16'hFFFF;

    typedef enum logic [1:0] {
        StIdle,
        StArm,
        StRead,
        StFill
    } sav_state_t;

    // Cartridge header byte 0x149 -> battery RAM size in bytes
    function automatic logic [17:0] sav_bytes(input logic [7:0] ram_size);
        logic [17:0] bytes;
        case (ram_size)
            8'd1:    bytes = 18'd2048;
            8'd2:    bytes = 18'd8192;
            8'd3:    bytes = 18'd32768;
            8'd4:    bytes = 18'd131072;
            8'd5:    bytes = 18'd65536;
            default: bytes = 18'd0;
        endcase
        return bytes;
    endfunction

endpackage

// File: rtl/gb_sav_uploader.sv
// Save-file write-back: serves HPS ioctl upload reads from cart RAM held in SDRAM.
// Each in-range read arms an SDRAM request on the ce slot and completes on the
// second ce; reads past the save size return the fill word without touching SDRAM.
// Also keeps a dirty flag so the OSD/autosave logic knows the cart RAM changed.
module gb_sav_uploader #(
    parameter logic [23:0] RAM_BASE = gb_pkg::RAM_BASE,
    parameter logic [15:0] FILL     = gb_pkg::FILL_WORD
) (
    input  logic        clk_sys,
    input  logic        reset,
    input  logic        ce,
    input  logic [7:0]  cart_ram_size,
    input  logic        cart_ram_wr,
    input  logic        ioctl_download,
    input  logic        ioctl_upload,
    input  logic        ioctl_rd,
    input  logic [24:0] ioctl_addr,
    output logic [15:0] ioctl_din,
    output logic        ioctl_wait,
    output logic        sd_oe,
    output logic [23:0] sd_addr,
    input  logic [15:0] sd_dout,
    output logic [17:0] sav_size,
    output logic        sav_dirty,
    output logic        core_hold
);
    import gb_pkg::*;

    sav_state_t  r_state;
    sav_state_t  w_next;
    logic [17:0] r_sav_size;
    logic [15:0] r_din;
    logic        r_wait;
    logic [23:0] r_sd_addr;
    logic        r_dirty;
    logic        r_upload_q;
    logic        r_download_q;

    logic        w_req;
    logic        w_out_of_range;
    logic        w_abort;
    logic        w_ram_write;
    logic        w_dirty_clr;

    assign w_req = ioctl_rd & ioctl_upload;
    // Sizes are even, so comparing the raw byte address equals comparing with bit 0 cleared
    assign w_out_of_range = ioctl_addr >= {7'd0, r_sav_size};
    // Upload dropping mid-transaction returns the FSM to idle without touching read data
    assign w_abort = (r_state != StIdle) & ~ioctl_upload;

    // State register
    always_ff @(posedge clk_sys) begin
        if (reset) begin
            r_state <= StIdle;
        end else begin
            r_state <= w_next;
        end
    end

    // Next-state logic
    always_comb begin
        w_next = r_state;
        if (w_abort) begin
            w_next = StIdle;
        end else begin
            case (r_state)
                StIdle:  if (w_req) w_next = w_out_of_range ? StFill : StArm;
                StArm:   if (ce) w_next = StRead;
                StRead:  if (ce) w_next = StIdle;
                StFill:  w_next = StIdle;
                default: w_next = StIdle;
            endcase
        end
    end

    // SDRAM request owns the port only while a read is armed or in flight during upload
    always_comb begin
        sd_oe = 1'b0;
        if (ioctl_upload && (r_state == StArm || r_state == StRead)) begin
            sd_oe = 1'b1;
        end
    end

    // Read datapath: size decode, request address latch, read data capture, wait flag
    always_ff @(posedge clk_sys) begin
        if (reset) begin
            r_sav_size <= '0;
            r_din      <= '0;
            r_wait     <= 1'b0;
            r_sd_addr  <= '0;
        end else begin
            r_sav_size <= sav_bytes(cart_ram_size);
            // Wait stays high for exactly as long as a transaction is open
            r_wait     <= (w_next != StIdle);
            if (r_state == StIdle && w_req && !w_out_of_range) begin
                r_sd_addr <= RAM_BASE | {5'd0, ioctl_addr[19:1]};
            end
            if (!w_abort && r_state == StRead && ce) begin
                r_din <= sd_dout;
            end
            if (!w_abort && r_state == StFill) begin
                r_din <= FILL;
            end
        end
    end

    assign w_ram_write = cart_ram_wr & ce;
    assign w_dirty_clr = (ioctl_upload & ~r_upload_q) | (ioctl_download & ~r_download_q);

    // Dirty tracking: a RAM write in the same cycle as a clearing edge wins
    always_ff @(posedge clk_sys) begin
        if (reset) begin
            r_dirty      <= 1'b0;
            r_upload_q   <= 1'b0;
            r_download_q <= 1'b0;
        end else begin
            r_upload_q   <= ioctl_upload;
            r_download_q <= ioctl_download;
            r_dirty      <= w_ram_write | (r_dirty & ~w_dirty_clr);
        end
    end

    assign ioctl_din  = r_din;
    assign ioctl_wait = r_wait;
    assign sd_addr    = r_sd_addr;
    assign sav_size   = r_sav_size;
    assign sav_dirty  = r_dirty;
    assign core_hold  = ioctl_upload;

endmodule

// File: tb/tb_gb_sav_uploader.sv
// Bench for gb_sav_uploader: SDRAM model with a word image, size-table vectors,
// hand sequences for abort/reset/dirty corners, a full 32K upload and random reads.
module tb_gb_sav_uploader;

    logic        clk_sys = 1'b0;
    logic        reset;
    logic        ce = 1'b0;
    logic [7:0]  cart_ram_size;
    logic        cart_ram_wr;
    logic        ioctl_download;
    logic        ioctl_upload;
    logic        ioctl_rd;
    logic [24:0] ioctl_addr;
    logic [15:0] ioctl_din;
    logic        ioctl_wait;
    logic        sd_oe;
    logic [23:0] sd_addr;
    logic [15:0] sd_dout;
    logic [17:0] sav_size;
    logic        sav_dirty;
    logic        core_hold;

    int total = 0;
    int bad   = 0;

    int ce_div = 8;
    int ce_cnt = 0;
    bit last_ce;

    logic [15:0] mem [0:65535];

    gb_sav_uploader dut (
        .clk_sys        (clk_sys),
        .reset          (reset),
        .ce             (ce),
        .cart_ram_size  (cart_ram_size),
        .cart_ram_wr    (cart_ram_wr),
        .ioctl_download (ioctl_download),
        .ioctl_upload   (ioctl_upload),
        .ioctl_rd       (ioctl_rd),
        .ioctl_addr     (ioctl_addr),
        .ioctl_din      (ioctl_din),
        .ioctl_wait     (ioctl_wait),
        .sd_oe          (sd_oe),
        .sd_addr        (sd_addr),
        .sd_dout        (sd_dout),
        .sav_size       (sav_size),
        .sav_dirty      (sav_dirty),
        .core_hold      (core_hold)
    );

    always #5 clk_sys = ~clk_sys;

    // ce strobe every ce_div clocks, changed away from the active edge
    always @(negedge clk_sys) begin
        ce_cnt = (ce_cnt + 1) % ce_div;
        ce     = (ce_cnt == 0);
    end

    function automatic logic [15:0] sdram_word(input logic [23:0] a);
        if (a[23:16] == 8'h10) return mem[a[15:0]];
        return 16'hDEAD;
    endfunction

    // SDRAM samples oe/addr on ce and presents the word until the next sample
    always @(posedge clk_sys) begin
        if (ce && sd_oe) sd_dout <= sdram_word(sd_addr);
    end

    function automatic int size_bytes(input logic [7:0] s);
        case (s)
            8'd1:    return 2048;
            8'd2:    return 8192;
            8'd3:    return 32768;
            8'd4:    return 131072;
            8'd5:    return 65536;
            default: return 0;
        endcase
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk_sys);
        last_ce = ce;
        #1;
    endtask

    task automatic do_read(input logic [24:0] addr, output logic [15:0] din, output int cyc,
                           output int ces, output bit saw_oe, output logic [23:0] oe_addr);
        ioctl_addr = addr;
        ioctl_rd   = 1'b1;
        tick();
        ioctl_rd = 1'b0;
        cyc      = 0;
        ces      = 0;
        saw_oe   = 1'b0;
        oe_addr  = '0;
        while (ioctl_wait === 1'b1 && cyc < 40) begin
            if (sd_oe === 1'b1) begin
                saw_oe  = 1'b1;
                oe_addr = sd_addr;
            end
            tick();
            cyc++;
            if (last_ce) ces++;
        end
        din = ioctl_din;
    endtask

    typedef struct {
        logic [7:0]  size;
        logic [24:0] addr;
        logic [17:0] exp_size;
        bit          exp_fill;
    } vec_t;

    vec_t        vecs [13];
    logic [15:0] din;
    logic [15:0] exp_din;
    logic [23:0] oe_addr;
    logic [24:0] ra;
    logic [7:0]  rs;
    int          cyc;
    int          ces;
    int          n;
    bit          saw_oe;
    bit          fill;

    initial begin
        #3_000_000;
        $display("FAIL watchdog: got timeout want finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        vecs[0]  = '{8'd3, 25'h20,      18'd32768,  1'b0};
        vecs[1]  = '{8'd2, 25'h2000,    18'd8192,   1'b1};
        vecs[2]  = '{8'd2, 25'h1FFE,    18'd8192,   1'b0};
        vecs[3]  = '{8'd1, 25'h7FE,     18'd2048,   1'b0};
        vecs[4]  = '{8'd1, 25'h800,     18'd2048,   1'b1};
        vecs[5]  = '{8'd4, 25'h1FFFE,   18'd131072, 1'b0};
        vecs[6]  = '{8'd4, 25'h20000,   18'd131072, 1'b1};
        vecs[7]  = '{8'd5, 25'hFFFE,    18'd65536,  1'b0};
        vecs[8]  = '{8'd5, 25'h10000,   18'd65536,  1'b1};
        vecs[9]  = '{8'd0, 25'h0,       18'd0,      1'b1};
        vecs[10] = '{8'd7, 25'h2,       18'd0,      1'b1};
        vecs[11] = '{8'd3, 25'h21,      18'd32768,  1'b0};
        vecs[12] = '{8'd3, 25'h1000020, 18'd32768,  1'b1};

        for (int i = 0; i < 65536; i++) mem[i] = 16'(i) ^ 16'hA5C3;
        mem[16'h10] = 16'hBEEF;

        reset          = 1'b1;
        cart_ram_size  = 8'd0;
        cart_ram_wr    = 1'b0;
        ioctl_download = 1'b0;
        ioctl_upload   = 1'b0;
        ioctl_rd       = 1'b0;
        ioctl_addr     = '0;
        repeat (3) tick();

        check("rst_din", ioctl_din, 0);
        check("rst_wait", ioctl_wait, 0);
        check("rst_oe", sd_oe, 0);
        check("rst_sd_addr", sd_addr, 0);
        check("rst_dirty", sav_dirty, 0);
        check("rst_hold", core_hold, 0);
        reset = 1'b0;
        tick();

        // Read request without upload level is ignored
        cart_ram_size = 8'd3;
        ioctl_addr    = 25'h20;
        ioctl_rd      = 1'b1;
        tick();
        ioctl_rd = 1'b0;
        check("rd_no_upload_wait", ioctl_wait, 0);
        check("rd_no_upload_oe", sd_oe, 0);

        ioctl_upload = 1'b1;
        tick();
        check("hold_follows_upload", core_hold, 1);

        // Size-table vectors at div-8 ce
        for (int i = 0; i < 13; i++) begin
            cart_ram_size = vecs[i].size;
            tick();
            tick();
            check($sformatf("size_%0d", i), sav_size, vecs[i].exp_size);
            do_read(vecs[i].addr, din, cyc, ces, saw_oe, oe_addr);
            exp_din = vecs[i].exp_fill ? 16'hFFFF : mem[vecs[i].addr[16:1]];
            check($sformatf("vec_din_%0d", i), din, exp_din);
            if (vecs[i].exp_fill) begin
                check($sformatf("vec_fill_cyc_%0d", i), cyc, 1);
                check($sformatf("vec_fill_oe_%0d", i), saw_oe, 0);
            end else begin
                check($sformatf("vec_ces_%0d", i), ces, 2);
                check($sformatf("vec_lat_ok_%0d", i), (cyc <= 16 && last_ce), 1);
                check($sformatf("vec_sd_addr_%0d", i), oe_addr,
                      24'h100000 + 24'(vecs[i].addr >> 1));
            end
            check($sformatf("vec_oe_after_%0d", i), sd_oe, 0);
        end

        // A second request while busy is ignored
        cart_ram_size = 8'd3;
        tick();
        tick();
        ioctl_addr = 25'h20;
        ioctl_rd   = 1'b1;
        tick();
        ioctl_addr = 25'h40;
        tick();
        ioctl_rd = 1'b0;
        n        = 0;
        while (ioctl_wait === 1'b1 && n < 40) begin
            tick();
            n++;
        end
        check("busy_rd_done", n < 40, 1);
        check("busy_rd_din", ioctl_din, 16'hBEEF);
        check("busy_rd_sd_addr", sd_addr, 24'h100010);
        tick();
        check("busy_rd_no_second", ioctl_wait, 0);

        // Upload dropped while armed aborts, then a fresh read works
        ioctl_addr = 25'h40;
        ioctl_rd   = 1'b1;
        tick();
        ioctl_rd     = 1'b0;
        ioctl_upload = 1'b0;
        tick();
        check("abort_wait", ioctl_wait, 0);
        check("abort_oe", sd_oe, 0);
        check("abort_din_kept", ioctl_din, 16'hBEEF);
        ioctl_upload = 1'b1;
        tick();
        do_read(25'h40, din, cyc, ces, saw_oe, oe_addr);
        check("after_abort_din", din, mem[16'h20]);
        check("after_abort_ces", ces, 2);

        // Dirty flag: set by write on ce, cleared by upload/download rise
        ioctl_upload = 1'b0;
        cart_ram_wr  = 1'b1;
        n            = 0;
        do begin
            tick();
            n++;
        end while (!last_ce && n < 20);
        cart_ram_wr = 1'b0;
        check("dirty_set", sav_dirty, 1);
        ioctl_upload = 1'b1;
        tick();
        check("dirty_clr_upload", sav_dirty, 0);
        ioctl_upload = 1'b0;
        cart_ram_wr  = 1'b1;
        n            = 0;
        do begin
            tick();
            n++;
        end while (!last_ce && n < 20);
        cart_ram_wr = 1'b0;
        check("dirty_set2", sav_dirty, 1);
        ioctl_download = 1'b1;
        tick();
        check("dirty_clr_download", sav_dirty, 0);
        ioctl_download = 1'b0;
        cart_ram_wr    = 1'b1;
        tick();
        cart_ram_wr = 1'b0;
        check("dirty_needs_ce", sav_dirty, last_ce);
        ce_div = 1;
        cart_ram_wr = 1'b1;
        tick();
        check("dirty_set3", sav_dirty, 1);
        ioctl_upload = 1'b1;
        tick();
        cart_ram_wr = 1'b0;
        check("dirty_set_wins", sav_dirty, 1);
        ce_div = 8;

        // Reset while the SDRAM read is in flight
        cart_ram_size = 8'd3;
        tick();
        ioctl_addr = 25'h20;
        ioctl_rd   = 1'b1;
        tick();
        ioctl_rd = 1'b0;
        n        = 0;
        while (!last_ce && n < 20) begin
            tick();
            n++;
        end
        check("in_read_before_reset", sd_oe, 1);
        reset = 1'b1;
        tick();
        check("rst_read_din", ioctl_din, 0);
        check("rst_read_wait", ioctl_wait, 0);
        check("rst_read_oe", sd_oe, 0);
        check("rst_read_sd_addr", sd_addr, 0);
        check("rst_read_dirty", sav_dirty, 0);
        reset = 1'b0;
        tick();
        tick();

        // Full 32K upload against a random image, ce every clock
        for (int i = 0; i < 16384; i++) mem[i] = 16'($urandom);
        ce_div        = 1;
        cart_ram_size = 8'd3;
        tick();
        tick();
        for (int i = 0; i < 16384; i++) begin
            do_read(25'(i * 2), din, cyc, ces, saw_oe, oe_addr);
            check($sformatf("upload_word_%0d", i), {din, cyc[15:0]}, {mem[i], 16'd2});
        end

        // Random sizes, addresses and ce rates against the reference rules
        for (int k = 0; k < 120; k++) begin
            rs            = 8'($urandom_range(0, 7));
            ra            = 25'($urandom_range(0, 32'h22000));
            ce_div        = $urandom_range(1, 8);
            cart_ram_size = rs;
            tick();
            tick();
            do_read(ra, din, cyc, ces, saw_oe, oe_addr);
            fill    = (int'(ra) >= size_bytes(rs));
            exp_din = fill ? 16'hFFFF : mem[ra[16:1]];
            check($sformatf("rand_din_%0d", k), din, exp_din);
            if (fill) begin
                check($sformatf("rand_fill_%0d", k), {saw_oe, cyc[7:0]}, {1'b0, 8'd1});
            end else begin
                check($sformatf("rand_read_%0d", k), {ces[7:0], oe_addr},
                      {8'd2, 24'h100000 + 24'(ra >> 1)});
            end
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
